// File: rtl/multicycle_core_param.sv
// Parametrised multicycle MIPS-style core: unified memory behind a req/ack handshake,
// HALT/illegal detection, retire strobe and a debug register read port.
module multicycle_core_param #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic              illegal,
    output logic              retire,
    output logic [ADDR_W-1:0] dbg_pc,
    input  logic [2:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int unsigned IR_W = 16;
    localparam int unsigned NREG = 8;

    localparam logic [3:0] OP_R    = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_LW   = 4'd2;
    localparam logic [3:0] OP_SW   = 4'd3;
    localparam logic [3:0] OP_BEQ  = 4'd4;
    localparam logic [3:0] OP_J    = 4'd5;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] pc, pc_d, addr_d, br_tgt;
    logic [IR_W-1:0]   ir, ir_d;
    logic [DATA_W-1:0] a, a_d, b, b_d, alu_q, alu_d, mdr, mdr_d, wdata_d;
    logic [DATA_W-1:0] imm, ea, alu_res, wr_val;
    logic              req_d, we_d, halted_d, illegal_d, retire_d, wr_en, op_bad;
    logic [2:0]        wr_idx;
    logic [DATA_W-1:0] rf [NREG];

    logic [3:0] op;
    logic [2:0] rs, rt, rd, fn;

    assign op  = ir[15:12];
    assign rs  = ir[11:9];
    assign rt  = ir[8:6];
    assign rd  = ir[5:3];
    assign fn  = ir[2:0];
    assign imm = {{(DATA_W-6){ir[5]}}, ir[5:0]};
    assign ea  = a + imm;
    assign br_tgt = pc + ADDR_W'(imm);

    assign dbg_pc   = pc;
    assign dbg_data = (dbg_sel == 3'd0) ? '0 : rf[dbg_sel];

    // R-type ALU on the latched operands
    always_comb begin
        alu_res = '0;
        case (fn)
            3'd0:    alu_res = a + b;
            3'd1:    alu_res = a - b;
            3'd2:    alu_res = a & b;
            3'd3:    alu_res = a | b;
            3'd4:    alu_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        op_bad = 1'b0;
        case (op)
            OP_R:                                          op_bad = (fn > 3'd4);
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT: op_bad = 1'b0;
            default:                                       op_bad = 1'b1;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state;
        pc_d      = pc;
        ir_d      = ir;
        a_d       = a;
        b_d       = b;
        alu_d     = alu_q;
        mdr_d     = mdr;
        req_d     = mem_req;
        we_d      = mem_we;
        addr_d    = mem_addr;
        wdata_d   = mem_wdata;
        halted_d  = halted;
        illegal_d = illegal;
        retire_d  = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = (op == OP_R) ? rd : rt;
        wr_val    = (op == OP_LW) ? mdr : alu_q;

        case (state)
            S_FETCH: begin
                if (!mem_req) begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = pc;
                end else if (mem_ack) begin
                    ir_d    = mem_rdata[IR_W-1:0];
                    pc_d    = pc + ADDR_W'(1);
                    req_d   = 1'b0;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d = (rs == 3'd0) ? '0 : rf[rs];
                b_d = (rt == 3'd0) ? '0 : rf[rt];
                if (op == OP_HALT) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else if (op_bad) begin
                    illegal_d = 1'b1;
                    halted_d  = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_R: begin
                        alu_d   = alu_res;
                        state_d = S_WB;
                    end
                    OP_ADDI: begin
                        alu_d   = ea;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_d   = ea;
                        req_d   = 1'b1;
                        we_d    = (op == OP_SW);
                        addr_d  = ea[ADDR_W-1:0];
                        wdata_d = b;
                        state_d = S_MEM;
                    end
                    default: begin
                        // BEQ / J complete here and go straight back to fetch
                        if (op == OP_J) begin
                            pc_d = ADDR_W'(ir[11:0]);
                        end else if (a == b) begin
                            pc_d = br_tgt;
                        end
                        req_d    = 1'b1;
                        we_d     = 1'b0;
                        addr_d   = pc_d;
                        retire_d = 1'b1;
                        state_d  = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ack) begin
                    req_d = 1'b0;
                    we_d  = 1'b0;
                    if (op == OP_SW) begin
                        // req must idle one cycle, so the next fetch raises it itself
                        retire_d = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                wr_en    = 1'b1;
                retire_d = 1'b1;
                req_d    = 1'b1;
                we_d     = 1'b0;
                addr_d   = pc;
                state_d  = S_FETCH;
            end
            default: begin
                req_d   = 1'b0;
                we_d    = 1'b0;
                state_d = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_FETCH;
            pc        <= ADDR_W'(RESET_PC);
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            alu_q     <= '0;
            mdr       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
            retire    <= 1'b0;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            ir        <= ir_d;
            a         <= a_d;
            b         <= b_d;
            alu_q     <= alu_d;
            mdr       <= mdr_d;
            mem_req   <= req_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            halted    <= halted_d;
            illegal   <= illegal_d;
            retire    <= retire_d;
            if (wr_en && (wr_idx != 3'd0)) rf[wr_idx] <= wr_val;
        end
    end

endmodule

// File: tb/tb_multicycle_core_param.sv
// Directed bench for multicycle_core_param: memory responder with programmable wait
// states, handshake monitors and hand-computed register/cycle expectations.
module tb_multicycle_core_param;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_req, mem_we, mem_ack = 1'b0;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata = '0;
    logic        halted, illegal, retire;
    logic [7:0]  dbg_pc;
    logic [2:0]  dbg_sel = '0;
    logic [15:0] dbg_data;

    multicycle_core_param dut (
        .clock(clock), .reset_n(reset_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .halted(halted), .illegal(illegal), .retire(retire),
        .dbg_pc(dbg_pc), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clock = ~clock;

    logic [15:0] mem [256];
    int n_cmp = 0, n_bad = 0;
    int ack_dly = 0;
    int rt_cnt = 0, req_cnt = 0, stab_err = 0, b2b_err = 0;
    int w_seen = 0;
    logic [7:0]  w_addr = '0;
    logic [15:0] w_data = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc_r(int rs, int rt, int rd, int fn);
        return {4'd0, 3'(rs), 3'(rt), 3'(rd), 3'(fn)};
    endfunction
    function automatic logic [15:0] enc_i(int op, int rs, int rt, int imm);
        return {4'(op), 3'(rs), 3'(rt), 6'(imm)};
    endfunction
    function automatic logic [15:0] enc_j(int tgt);
        return {4'd5, 12'(tgt)};
    endfunction

    // Memory responder and handshake monitor, all on the falling edge
    initial begin
        int wait_cnt = 0;
        bit in_req = 0, acked_prev = 0;
        logic [7:0]  h_addr = '0;
        logic        h_we = 1'b0;
        logic [15:0] h_wd = '0;
        forever begin
            @(negedge clock);
            if (retire) rt_cnt++;
            if (mem_req) begin
                req_cnt++;
                if (acked_prev) b2b_err++;
                if (!in_req) begin
                    in_req = 1; h_addr = mem_addr; h_we = mem_we; h_wd = mem_wdata;
                end else if (mem_addr !== h_addr || mem_we !== h_we || mem_wdata !== h_wd) begin
                    stab_err++;
                end
                if (wait_cnt >= ack_dly) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem[mem_addr];
                    if (mem_we) begin
                        mem[mem_addr] = mem_wdata;
                        w_seen++; w_addr = mem_addr; w_data = mem_wdata;
                    end
                    wait_cnt = 0; in_req = 0; acked_prev = 1;
                end else begin
                    mem_ack = 1'b0; wait_cnt++; acked_prev = 0;
                end
            end else begin
                mem_ack = 1'b0; wait_cnt = 0; in_req = 0; acked_prev = 0;
            end
        end
    end

    task automatic rd_reg(input int idx, output logic [15:0] v);
        dbg_sel = 3'(idx);
        #1;
        v = dbg_data;
    endtask

    task automatic hold_reset();
        reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    // Release reset and return just after the edge that raises the first fetch
    task automatic start();
        @(negedge clock);
        rt_cnt = 0; w_seen = 0;
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (mem_req) break;
        end
        check("first_req", 32'(mem_req), 1);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic run_halt(output int n);
        n = 0;
        while (!halted && n < 300) begin
            @(posedge clock); #1; n++;
        end
        if (!halted) check("halt_timeout", 32'(halted), 1);
    endtask

    task automatic load_prog1();
        mem[0] = enc_i(1, 0, 1, 5);     // ADDI R1=R0+5
        mem[1] = enc_i(1, 1, 2, -3);    // ADDI R2=R1-3
        mem[2] = enc_r(1, 2, 3, 0);     // ADD R3=R1+R2
        mem[3] = 16'hF000;              // HALT
    endtask

    initial begin
        int n;
        logic [15:0] v;

        // 1: basic program, zero wait
        hold_reset(); load_prog1(); start();
        run_halt(n);
        check("t1_cycles", 32'(n), 14);
        rd_reg(1, v); check("t1_r1", 32'(v), 5);
        rd_reg(2, v); check("t1_r2", 32'(v), 2);
        rd_reg(3, v); check("t1_r3", 32'(v), 7);
        check("t1_retires", 32'(rt_cnt), 3);
        check("t1_illegal", 32'(illegal), 0);

        // 2: reset state, then same program with 3 wait states per access
        hold_reset();
        check("rst_req", 32'(mem_req), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_illegal", 32'(illegal), 0);
        check("rst_retire", 32'(retire), 0);
        check("rst_pc", 32'(dbg_pc), 0);
        rd_reg(3, v); check("rst_r3", 32'(v), 0);
        load_prog1(); ack_dly = 3; stab_err = 0; start();
        run_halt(n);
        check("t2_cycles", 32'(n), 26);
        rd_reg(3, v); check("t2_r3", 32'(v), 7);
        check("t2_retires", 32'(rt_cnt), 3);
        check("t2_stable", 32'(stab_err), 0);
        ack_dly = 0;

        // 3: store then load through memory; 4+4+1 idle+5+2 cycles
        hold_reset();
        mem[0] = enc_i(1, 0, 3, 7);
        mem[1] = enc_i(3, 0, 3, 20);    // SW R3,[R0+20]
        mem[2] = enc_i(2, 0, 4, 20);    // LW R4,[R0+20]
        mem[3] = 16'hF000;
        start(); run_halt(n);
        check("t3_cycles", 32'(n), 16);
        check("t3_wcount", 32'(w_seen), 1);
        check("t3_waddr", 32'(w_addr), 20);
        check("t3_wdata", 32'(w_data), 7);
        check("t3_mem20", 32'(mem[20]), 7);
        rd_reg(4, v); check("t3_r4", 32'(v), 7);

        // 4a: BEQ not taken falls through to HALT at 11
        hold_reset();
        mem[0]  = enc_i(1, 0, 1, 1);
        mem[1]  = enc_j(10);
        mem[10] = enc_i(4, 1, 0, -1);
        mem[11] = 16'hF000;
        start(); run_halt(n);
        check("t4a_halted", 32'(halted), 1);
        check("t4a_pc", 32'(dbg_pc), 12);
        check("t4a_retires", 32'(rt_cnt), 3);

        // 4b: BEQ taken with imm=-1 spins at PC 10
        hold_reset();
        mem[0]  = enc_j(10);
        mem[10] = enc_i(4, 0, 0, -1);
        start();
        cycles(10);
        check("t4b_pc_fetched", 32'(dbg_pc), 11);
        cycles(2);
        check("t4b_pc_taken", 32'(dbg_pc), 10);
        check("t4b_req", 32'(mem_req), 1);
        check("t4b_addr", 32'(mem_addr), 10);

        // 4c: J 0xFFF truncates to 0xFF, fetch at 0xFF wraps PC to 0
        hold_reset();
        mem[0]   = enc_j(12'hFFF);
        mem[255] = enc_i(1, 0, 5, 9);
        start();
        cycles(3);
        check("t4c_pc_ff", 32'(dbg_pc), 8'hFF);
        check("t4c_addr_ff", 32'(mem_addr), 8'hFF);
        cycles(1);
        check("t4c_pc_wrap", 32'(dbg_pc), 0);
        cycles(3);
        rd_reg(5, v); check("t4c_r5", 32'(v), 9);
        check("t4c_addr_0", 32'(mem_addr), 0);

        // 5: ALU ops, R0 write discard, then opcode 7
        hold_reset();
        mem[0] = enc_i(1, 0, 1, 1);     // R1=1
        mem[1] = enc_i(1, 0, 2, -1);    // R2=FFFF
        mem[2] = enc_i(1, 0, 6, 12);    // R6=12
        mem[3] = enc_r(2, 1, 3, 4);     // SLT R3 = -1<1
        mem[4] = enc_r(1, 2, 4, 1);     // SUB R4 = 1-(-1)
        mem[5] = enc_r(1, 6, 7, 3);     // OR  R7 = 1|12
        mem[6] = enc_r(6, 7, 5, 2);     // AND R5 = 12&13
        mem[7] = enc_r(1, 1, 0, 0);     // ADD R0 (discarded)
        mem[8] = 16'h7000;
        start(); run_halt(n);
        check("t5_illegal", 32'(illegal), 1);
        check("t5_halted", 32'(halted), 1);
        rd_reg(2, v); check("t5_r2", 32'(v), 16'hFFFF);
        rd_reg(3, v); check("t5_slt", 32'(v), 1);
        rd_reg(4, v); check("t5_sub", 32'(v), 2);
        rd_reg(7, v); check("t5_or", 32'(v), 13);
        rd_reg(5, v); check("t5_and", 32'(v), 12);
        rd_reg(0, v); check("t5_r0", 32'(v), 0);
        req_cnt = 0;
        cycles(20);
        check("t5_no_req", 32'(req_cnt), 0);
        check("t5_retires", 32'(rt_cnt), 8);
        check("t5_still_halted", 32'(halted), 1);

        // 5b: R-type fn 5 is illegal
        hold_reset();
        mem[0] = enc_r(0, 0, 0, 5);
        start(); run_halt(n);
        check("t5b_cycles", 32'(n), 2);
        check("t5b_illegal", 32'(illegal), 1);

        // 6: reset while a fetch is stalled
        hold_reset(); load_prog1(); start();
        cycles(7);
        ack_dly = 100;
        cycles(3);
        check("t6_req_pending", 32'(mem_req), 1);
        check("t6_addr_pending", 32'(mem_addr), 2);
        #2 reset_n = 1'b0;
        #1;
        check("t6_req_dropped", 32'(mem_req), 0);
        check("t6_pc_reset", 32'(dbg_pc), 0);
        rd_reg(1, v); check("t6_r1_reset", 32'(v), 0);
        ack_dly = 0;
        start();
        check("t6_restart_addr", 32'(mem_addr), 0);
        run_halt(n);
        check("t6_cycles", 32'(n), 14);
        rd_reg(3, v); check("t6_r3", 32'(v), 7);

        check("hs_stable", 32'(stab_err), 0);
        check("no_b2b_req", 32'(b2b_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
